// File: rtl/nios_pio_input_edge_pkg.sv
// Shared definitions for the Nios PIO edge-capture input port:
// register word addresses and edge-type encodings.
package nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios_pio_input_edge_if.sv
// Avalon-MM slave bus bundle between the Nios data master and the PIO port.
interface nios_pio_input_edge_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_pio_input_edge_sync_edge.sv
// Input synchroniser, previous-sample register and post-reset settle window
// producing the synchronised inputs and the selected per-bit edge vector.
module pio_sync_edge
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] s_in,
    output logic [WIDTH-1:0] edge_vec
);

    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int CW     = $clog2(SETTLE + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] p_in;
    logic [CW-1:0]    settle_cnt;
    logic             settled;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            p_in       <= '0;
            settle_cnt <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            p_in <= s_in;
            if (!settled) begin
                settle_cnt <= settle_cnt + CW'(1);
            end
        end
    end

    assign s_in    = sync_q[SYNC_STAGES-1];
    assign settled = (settle_cnt == CW'(SETTLE));

    // Edges are suppressed until the chain and p_in hold real samples,
    // so inputs already high at reset release are never captured.
    always_comb begin
        rise = s_in & ~p_in;
        fall = ~s_in & p_in;
        case (EDGE_TYPE)
            EDGE_FALL: sel = fall;
            EDGE_ANY:  sel = rise | fall;
            default:   sel = rise;
        endcase
        edge_vec = settled ? sel : '0;
    end

endmodule

// File: rtl/nios_pio_input_edge.sv
// Avalon-MM PIO input port with synchronised inputs, sticky edge capture,
// interrupt mask and registered level IRQ.
module nios_pio_input_edge
    import nios_pio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nios_pio_input_edge_if.slave  bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    logic [31:0]      rd_mux;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .s_in     (s_in),
        .edge_vec (edge_vec)
    );

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign clr   = (wr_en && (bus.address == ADDR_EDGE)) ? bus.writedata[WIDTH-1:0] : '0;

    // Reads depend on address only, so they never disturb any state.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux = 32'(s_in);
            ADDR_MASK: rd_mux = 32'(irqmask);
            ADDR_EDGE: rd_mux = 32'(edgecapture);
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask      <= RESET_MASK;
            edgecapture  <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            if (wr_en && (bus.address == ADDR_MASK)) begin
                irqmask <= bus.writedata[WIDTH-1:0];
            end
            edgecapture  <= (edgecapture & ~clr) | edge_vec;
            irq          <= |(edgecapture & irqmask);
            bus.readdata <= rd_mux;
        end
    end

endmodule
